toggle_event_decoder: RTL
=========================

Name: toggle_event_decoder

Overview:
- Receiving end of the debounced-button toggle interface: each toggle-level signal (energy, medicine, test, test-mode, photocell, ultrasonic) flips once per user or sensor action.
- Block synchronises each level and turns every transition back into exactly one event.
- Events are arbitrated by fixed priority and buffered in a small FIFO.
- The pet state machine consumes events one at a time over a valid/ready handshake.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- TS_W, 16, timestamp width; used only when EVT_TIMESTAMP_EN is defined.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- tgl_energia  in  1  energy toggle level
- tgl_medicina  in  1  medicine toggle level
- tgl_test  in  1  test toggle level
- tgl_test_mode  in  1  test-mode toggle level
- tgl_fot  in  1  photocell toggle level
- tgl_ult  in  1  ultrasonic toggle level
- evt_ready  in  1  consumer accepts head event
- clr_ovf  in  1  clears evt_overflow
- evt_valid  out  1  FIFO not empty
- evt_code  out  3  head event code
- evt_overflow  out  1  sticky event-loss flag
- fifo_level  out  $clog2(DEPTH)+1  current occupancy
- evt_stamp  out  TS_W  head timestamp (EVT_TIMESTAMP_EN only)

Behaviour:
- Event codes:
  - 1 ENERGIA, 2 MEDICINA, 3 TEST, 4 TEST_MODE, 5 FOT, 6 ULT.
  - 0 and 7 are never emitted.
- Per-input synchronizer: 3 flops s1 -> s2 -> s3; edge = s2 XOR s3. Both rising and falling transitions count as events.
- During reset, s1, s2 and s3 all load the raw input, so a high level at reset release produces no event.
- Reset values:
  - All pending bits cleared and FIFO emptied.
  - evt_valid=0, evt_code=0, evt_overflow=0, fifo_level=0, timestamp counter=0.
- Pending bits, one per source:
  - Set at the clock edge following edge=1.
  - Cleared when the source is granted.
  - If a new edge arrives while the bit is already set and not granted that cycle, the event is lost and evt_overflow is set.
  - If a new edge and a grant coincide, the bit stays 1 (no loss).
- Arbiter:
  - At most one grant per cycle.
  - Fixed priority: TEST_MODE > TEST > MEDICINA > ENERGIA > ULT > FOT.
  - Grant is allowed when the FIFO is not full, or when it is full and a pop happens the same cycle.
- FIFO:
  - Circular buffer with wrap-around pointers.
  - Push = grant; pop = evt_valid & evt_ready.
  - Simultaneous push and pop leaves fifo_level unchanged.
  - evt_code shows the head entry; it is 0 when empty.
  - evt_valid = (fifo_level != 0).
  - evt_code is held stable while evt_valid=1 and evt_ready=0.
- Latency: the input level is captured by s1 at edge N; with the FIFO empty and no competing sources, evt_valid=1 after edge N+3.
- evt_overflow: set on any lost event; cleared by clr_ovf (clr_ovf loses to a simultaneous set) or by reset.
- Reset mid-operation discards all queued and pending events.

Optional Feature:
- Macro EVT_TIMESTAMP_EN.
- Defined:
  - Free-running TS_W counter, wrapping at 2^TS_W-1 -> 0.
  - The counter value at grant is stored with each entry and presented on evt_stamp alongside evt_code.
- Undefined: no counter, no stamp storage, evt_stamp port absent.

Test Plan:
- Reset release with tgl_energia=1 held -> no event, evt_valid=0 for 10 cycles.
- Single toggle of tgl_medicina at edge 5, evt_ready=1 -> evt_valid high after edge 8 for one cycle, evt_code=2, fifo_level returns to 0.
- tgl_fot, tgl_test and tgl_test_mode toggled in the same cycle, evt_ready=0 -> FIFO order 4, 3, 5, fifo_level=3; then evt_ready=1 -> pops in that order.
- DEPTH=4, evt_ready=0, six distinct sources toggled -> fifo_level=4, codes 4, 3, 2, 1, 6 and FOT pending. Then toggle tgl_fot again -> evt_overflow=1. Then clr_ovf -> 0.
- FIFO full with evt_ready=1 and a pending source -> push and pop in the same cycle, fifo_level stays 4, no overflow.
- With EVT_TIMESTAMP_EN, TS_W=4: toggle tgl_ult at counter 14 and again 4 cycles later -> two events, code 6, with stamps differing by 4 modulo 16 (wrap through 0).

Source files
------------

// File: rtl/toggle_event_decoder.sv
// toggle_event_decoder: turns six toggle levels into one-shot event codes
// and queues them for a valid/ready consumer in a small FIFO.
//
// Ports:
//   clk, reset (sync, active-high)
//   tgl_*        toggle levels, one flip per action
//   evt_ready    consumer accepts head event
//   clr_ovf      clears evt_overflow
//   evt_valid    FIFO not empty
//   evt_code     head event code (0 when empty)
//   evt_overflow sticky event-loss flag
//   fifo_level   current occupancy
//   evt_stamp    head grant timestamp (EVT_TIMESTAMP_EN only)
//
// Build option: define EVT_TIMESTAMP_EN to add the timestamp counter,
// per-entry stamp storage and the evt_stamp port.
module toggle_event_decoder #(
  parameter int DEPTH = 4,
  parameter int TS_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tgl_energia,
  input  logic                     tgl_medicina,
  input  logic                     tgl_test,
  input  logic                     tgl_test_mode,
  input  logic                     tgl_fot,
  input  logic                     tgl_ult,
  input  logic                     evt_ready,
  input  logic                     clr_ovf,
  output logic                     evt_valid,
  output logic [2:0]               evt_code,
  output logic                     evt_overflow,
  output logic [$clog2(DEPTH):0]   fifo_level
`ifdef EVT_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]          evt_stamp
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("DEPTH must be a power of 2, at least 2");
  end
  if (TS_W < 1) begin : g_tsw_chk
    $error("TS_W must be at least 1");
  end

  // Bit i holds the source whose event code is i+1.
  logic [5:0] raw;
  assign raw = {tgl_ult, tgl_fot, tgl_test_mode,
                tgl_test, tgl_medicina, tgl_energia};

  logic [5:0] s1_q, s2_q, s3_q;
  logic [5:0] edge_w;

  // Loading the raw level into all stages during reset means a level
  // already high at release is not mistaken for a transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= raw;
      s2_q <= raw;
      s3_q <= raw;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign edge_w = s2_q ^ s3_q;

  logic [5:0]    pend_q, pend_d;
  logic [5:0]    gnt;
  logic [2:0]    gnt_code;
  logic          push, pop, can_push;
  logic          lost;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [2:0]    mem_code [DEPTH];

  assign pop      = evt_valid & evt_ready;
  // A full FIFO still accepts a push when the head leaves this cycle.
  assign can_push = (cnt_q != CNT_FULL) | pop;

  always_comb begin
    gnt      = '0;
    gnt_code = 3'd0;
    if (can_push) begin
      if (pend_q[3]) begin
        gnt[3] = 1'b1; gnt_code = 3'd4;
      end else if (pend_q[2]) begin
        gnt[2] = 1'b1; gnt_code = 3'd3;
      end else if (pend_q[1]) begin
        gnt[1] = 1'b1; gnt_code = 3'd2;
      end else if (pend_q[0]) begin
        gnt[0] = 1'b1; gnt_code = 3'd1;
      end else if (pend_q[5]) begin
        gnt[5] = 1'b1; gnt_code = 3'd6;
      end else if (pend_q[4]) begin
        gnt[4] = 1'b1; gnt_code = 3'd5;
      end
    end
  end

  assign push = |gnt;

  // An edge on a source already pending (and not being granted) is lost;
  // an edge coinciding with a grant simply re-arms the bit.
  assign lost   = |(edge_w & pend_q & ~gnt);
  assign pend_d = (pend_q & ~gnt) | edge_w;

  always_comb begin
    ovf_d = ovf_q;
    if (lost) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      wr_d = wr_q + AW'(1);
    end
    if (pop) begin
      rd_d = rd_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
      ovf_q  <= 1'b0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_code[wr_q] <= gnt_code;
    end
  end

  assign evt_valid    = (cnt_q != '0);
  assign evt_code     = evt_valid ? mem_code[rd_q] : 3'd0;
  assign evt_overflow = ovf_q;
  assign fifo_level   = cnt_q;

`ifdef EVT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d;
  logic [TS_W-1:0] mem_ts [DEPTH];

  assign ts_d = ts_q + TS_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_ts[wr_q] <= ts_q;
    end
  end

  assign evt_stamp = evt_valid ? mem_ts[rd_q] : '0;
`endif

endmodule
